// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared pipeline constants: control-bit layout and occupancy helper
package pipe_stage_pkg;

    localparam int CTRL_W_DEF   = 3;
    localparam int WB_EN_BIT    = 0;
    localparam int MEM_R_EN_BIT = 1;
    localparam int MEM_W_EN_BIT = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        return {main_valid & skid_valid, main_valid ^ skid_valid};
    endfunction

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enable register with asynchronous active-low clear
module en_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry: valid, control bits and packed payload
module pipe_slot #(
    parameter int CTRL_W    = 3,
    parameter int PAYLOAD_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [CTRL_W-1:0]    next_ctrl,
    input  logic [PAYLOAD_W-1:0] next_payload,
    output logic                 valid,
    output logic [CTRL_W-1:0]    ctrl,
    output logic [PAYLOAD_W-1:0] payload
);

    // Clearing zeroes ctrl alongside valid so an empty slot is always a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= next_ctrl;
        end
    end

    en_reg #(.W(PAYLOAD_W)) u_payload (
        .clk (clk),
        .rst (rst),
        .en  (load & ~clear),
        .d   (next_payload),
        .q   (payload)
    );

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - registered pipeline stage with optional two-entry skid buffer
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DEST_W-1:0] out_dest,
    output logic [1:0]        occupancy
);

    localparam int PW = DEST_W + 2 * DATA_W;

    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     main_payload;
    logic [PW-1:0]     skid_payload;
    logic [PW-1:0]     main_next_payload;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [CTRL_W-1:0] main_next_ctrl;
    logic              main_valid;
    logic              skid_valid;
    logic              main_load;
    logic              main_clear;
    logic              in_fire;
    logic              out_fire;

    assign in_payload = {in_dest, in_data1, in_data0};
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = main_valid & out_ready;

    // A held skid entry is always older than the input, so it refills main first.
    assign main_next_ctrl    = skid_valid ? skid_ctrl    : in_ctrl;
    assign main_next_payload = skid_valid ? skid_payload : in_payload;

    generate
        if (SKID != 0) begin : g_skid
            logic skid_load;
            logic skid_clear;

            assign in_ready   = ~skid_valid;
            assign main_load  = ~flush & ((out_fire & skid_valid) |
                                          (in_fire & (~main_valid | out_fire)));
            assign main_clear = flush | (out_fire & ~in_fire & ~skid_valid);
            assign skid_load  = ~flush & in_fire & main_valid & ~out_fire;
            assign skid_clear = flush | (out_fire & skid_valid);

            pipe_slot #(.CTRL_W(CTRL_W), .PAYLOAD_W(PW)) u_skid (
                .clk          (clk),
                .rst          (rst),
                .load         (skid_load),
                .clear        (skid_clear),
                .next_ctrl    (in_ctrl),
                .next_payload (in_payload),
                .valid        (skid_valid),
                .ctrl         (skid_ctrl),
                .payload      (skid_payload)
            );
        end else begin : g_noskid
            assign in_ready     = ~main_valid | out_ready;
            assign main_load    = ~flush & in_fire;
            assign main_clear   = flush | (out_fire & ~in_fire);
            assign skid_valid   = 1'b0;
            assign skid_ctrl    = '0;
            assign skid_payload = '0;
        end
    endgenerate

    pipe_slot #(.CTRL_W(CTRL_W), .PAYLOAD_W(PW)) u_main (
        .clk          (clk),
        .rst          (rst),
        .load         (main_load),
        .clear        (main_clear),
        .next_ctrl    (main_next_ctrl),
        .next_payload (main_next_payload),
        .valid        (main_valid),
        .ctrl         (main_ctrl),
        .payload      (main_payload)
    );

    assign out_valid                         = main_valid;
    assign out_ctrl                          = main_ctrl;
    assign {out_dest, out_data1, out_data0}  = main_payload;
    assign occupancy                         = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - self-checking bench for pipe_stage in skid and single-entry builds
module tb_pipe_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // a_*: SKID=1 instance, b_*: SKID=0 instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data0, a_in_data1, a_out_data0, a_out_data1;
    logic [3:0]  a_in_dest, a_out_dest;
    logic [1:0]  a_occ;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data0, b_in_data1, b_out_data0, b_out_data1;
    logic [3:0]  b_in_dest, b_out_dest;
    logic [1:0]  b_occ;

    pipe_stage #(.SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl),
        .in_data0(a_in_data0), .in_data1(a_in_data1), .in_dest(a_in_dest),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data0(a_out_data0), .out_data1(a_out_data1), .out_dest(a_out_dest),
        .occupancy(a_occ)
    );

    pipe_stage #(.SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
        .in_data0(b_in_data0), .in_data1(b_in_data1), .in_dest(b_in_dest),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data0(b_out_data0), .out_data1(b_out_data1), .out_dest(b_out_dest),
        .occupancy(b_occ)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] d0;
        logic [2:0]  ctl;
        logic        e_ov;
        logic [31:0] e_d0;
        logic [2:0]  e_ctl;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  dest;
    } ent_t;

    vec_t tbl[16];
    ent_t qa[$];
    ent_t qb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0;
        a_in_data0 = 0; a_in_data1 = 0; a_in_dest = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0;
        b_in_data0 = 0; b_in_data1 = 0; b_in_dest = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_model(input string tag, input logic skid, input ent_t q[$],
                               input logic ov, input logic [2:0] octl, input logic [1:0] occ,
                               input logic ir, input logic ordy, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [3:0] dest);
        int sz;
        logic exp_ir;
        sz = q.size();
        exp_ir = skid ? (sz < 2) : (sz == 0 || ordy);
        chk({tag, ".out_valid"}, 64'(ov), 64'(sz > 0));
        chk({tag, ".occupancy"}, 64'(occ), 64'(sz));
        chk({tag, ".in_ready"}, 64'(ir), 64'(exp_ir));
        if (sz > 0) begin
            chk({tag, ".out_ctrl"}, 64'(octl), 64'(q[0].ctl));
            chk({tag, ".out_data0"}, 64'(d0), 64'(q[0].d0));
            chk({tag, ".out_data1"}, 64'(d1), 64'(q[0].d1));
            chk({tag, ".out_dest"}, 64'(dest), 64'(q[0].dest));
        end else begin
            chk({tag, ".bubble_ctrl"}, 64'(octl), 64'd0);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'hAA, 3'b001, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'b000, 1'b1, 32'hAA, 3'b001, 2'd1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'h0,  3'b000, 1'b1, 32'hAA, 3'b001, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h11, 3'b001, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h22, 3'b010, 1'b1, 32'h11, 3'b001, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h33, 3'b100, 1'b1, 32'h11, 3'b001, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h33, 3'b100, 1'b1, 32'h11, 3'b001, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h33, 3'b100, 1'b1, 32'h22, 3'b010, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0,  3'b000, 1'b1, 32'h33, 3'b100, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h44, 3'b001, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h55, 3'b001, 1'b1, 32'h44, 3'b001, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h66, 3'b011, 1'b1, 32'h44, 3'b001, 2'd2, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h77, 3'b001, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  3'b000, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h88, 3'b110, 1'b0, 32'h0,  3'b000, 2'd0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h0,  3'b000, 1'b1, 32'h88, 3'b110, 2'd1, 1'b1};

        do_reset();
        @(negedge clk);
        chk("reset.a_out_valid", 64'(a_out_valid), 64'd0);
        chk("reset.a_occupancy", 64'(a_occ), 64'd0);
        chk("reset.a_in_ready", 64'(a_in_ready), 64'd1);
        chk("reset.a_out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("reset.a_out_data0", 64'(a_out_data0), 64'd0);
        chk("reset.b_out_valid", 64'(b_out_valid), 64'd0);
        chk("reset.b_in_ready", 64'(b_in_ready), 64'd1);
        tick();

        for (int i = 0; i < 16; i++) begin
            a_flush = tbl[i].fl; a_in_valid = tbl[i].iv; a_out_ready = tbl[i].ordy;
            a_in_data0 = tbl[i].d0; a_in_data1 = ~tbl[i].d0;
            a_in_dest = tbl[i].d0[3:0]; a_in_ctrl = tbl[i].ctl;
            @(negedge clk);
            chk($sformatf("tbl%0d.out_valid", i), 64'(a_out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("tbl%0d.out_ctrl", i), 64'(a_out_ctrl), 64'(tbl[i].e_ctl));
            chk($sformatf("tbl%0d.occupancy", i), 64'(a_occ), 64'(tbl[i].e_occ));
            chk($sformatf("tbl%0d.in_ready", i), 64'(a_in_ready), 64'(tbl[i].e_ir));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_data0", i), 64'(a_out_data0), 64'(tbl[i].e_d0));
            tick();
        end

        // streaming: one output per cycle, no bubbles
        for (int i = 0; i < 17; i++) begin
            a_flush = 0; a_in_valid = 1; a_out_ready = 1; a_in_ctrl = 3'b001;
            a_in_data0 = 32'h100 + 32'(i);
            @(negedge clk);
            chk($sformatf("stream%0d.in_ready", i), 64'(a_in_ready), 64'd1);
            if (i > 0) begin
                chk($sformatf("stream%0d.out_valid", i), 64'(a_out_valid), 64'd1);
                chk($sformatf("stream%0d.out_data0", i), 64'(a_out_data0), 64'h100 + 64'(i - 1));
            end
            tick();
        end
        a_in_valid = 0;
        @(negedge clk);
        chk("stream.last", 64'(a_out_data0), 64'h110);
        tick();

        // single-entry build: combinational in_ready and same-cycle replace
        b_in_valid = 1; b_out_ready = 0; b_in_data0 = 32'h5A; b_in_ctrl = 3'b001;
        @(negedge clk);
        chk("noskid.empty_ready", 64'(b_in_ready), 64'd1);
        tick();
        b_in_data0 = 32'h5B;
        @(negedge clk);
        chk("noskid.held_data", 64'(b_out_data0), 64'h5A);
        chk("noskid.stall_ready", 64'(b_in_ready), 64'd0);
        tick();
        b_out_ready = 1;
        @(negedge clk);
        chk("noskid.pass_ready", 64'(b_in_ready), 64'd1);
        tick();
        b_in_valid = 0; b_out_ready = 0;
        @(negedge clk);
        chk("noskid.replaced", 64'(b_out_data0), 64'h5B);
        chk("noskid.occupancy", 64'(b_occ), 64'd1);
        tick();

        // asynchronous reset mid-stream with two entries held
        a_out_ready = 0; a_in_valid = 1; a_in_data0 = 32'hD1;
        tick();
        a_in_data0 = 32'hD2;
        tick();
        a_in_valid = 0;
        @(negedge clk);
        chk("areset.pre_occ", 64'(a_occ), 64'd2);
        #1 rst = 1'b0;
        #1;
        chk("areset.out_valid", 64'(a_out_valid), 64'd0);
        chk("areset.occupancy", 64'(a_occ), 64'd0);
        chk("areset.out_ctrl", 64'(a_out_ctrl), 64'd0);
        chk("areset.b_out_valid", 64'(b_out_valid), 64'd0);
        tick();

        // randomized run against queue models
        do_reset();
        qa.delete();
        qb.delete();
        for (int c = 0; c < 500; c++) begin
            logic a_ir_exp, b_ir_exp;
            ent_t ea, eb;
            a_flush = ($urandom_range(0, 19) == 0); a_in_valid = $urandom_range(0, 1) == 1;
            a_out_ready = $urandom_range(0, 2) != 0; a_in_ctrl = 3'($urandom);
            a_in_data0 = $urandom; a_in_data1 = $urandom; a_in_dest = 4'($urandom);
            b_flush = ($urandom_range(0, 19) == 0); b_in_valid = $urandom_range(0, 1) == 1;
            b_out_ready = $urandom_range(0, 2) != 0; b_in_ctrl = 3'($urandom);
            b_in_data0 = $urandom; b_in_data1 = $urandom; b_in_dest = 4'($urandom);
            @(negedge clk);
            check_model($sformatf("rnd%0d.a", c), 1'b1, qa, a_out_valid, a_out_ctrl, a_occ,
                        a_in_ready, a_out_ready, a_out_data0, a_out_data1, a_out_dest);
            check_model($sformatf("rnd%0d.b", c), 1'b0, qb, b_out_valid, b_out_ctrl, b_occ,
                        b_in_ready, b_out_ready, b_out_data0, b_out_data1, b_out_dest);
            a_ir_exp = qa.size() < 2;
            b_ir_exp = (qb.size() == 0) || b_out_ready;
            ea = '{a_in_ctrl, a_in_data0, a_in_data1, a_in_dest};
            eb = '{b_in_ctrl, b_in_data0, b_in_data1, b_in_dest};
            if (a_flush) qa.delete();
            else begin
                if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
                if (a_in_valid && a_ir_exp) qa.push_back(ea);
            end
            if (b_flush) qb.delete();
            else begin
                if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
                if (b_in_valid && b_ir_exp) qb.push_back(eb);
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of each of the two data fields (ALU result, store value).
REQ-002 Parameter DEST_W, default 4, destination register index width.
REQ-003 Parameter CTRL_W, default 3, control-bit vector width (bit0 WB_en, bit1 MEM_R_EN, bit2 MEM_W_EN).
REQ-004 Parameter SKID, default 1; 1 = two-entry skid-buffered stage, 0 = single-entry stage.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 flush  in  1  synchronous kill of all held entries.
REQ-008 in_valid  in  1  upstream entry present.
REQ-009 in_ready  out  1  stage accepts an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 in_data0 / in_data1  in  DATA_W each  ALU result / store value.
REQ-012 in_dest  in  DEST_W  destination index.
REQ-013 out_valid  out  1  output entry present.
REQ-014 out_ready  in  1  downstream accepts output.
REQ-015 out_ctrl, out_data0, out_data1, out_dest  out  CTRL_W/DATA_W/DATA_W/DEST_W  output entry fields.
REQ-016 occupancy  out  2  held entry count, 0..2.

Function
REQ-017 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; one entry moves per fire.
REQ-018 Output side is the main register; out_* fields come directly from it (no combinational input-to-output path).
REQ-019 SKID=1: in_ready = ~skid_full, driven from a flop only (no combinational dependence on out_ready).
REQ-020 SKID=1 transfers: in fire with main empty or output fire -> main <= input; in fire with main full and no output fire -> skid <= input; output fire with skid full -> main <= skid, skid empty; output fire with no in fire and skid empty -> main empty.
REQ-021 Ordering is strict FIFO; an entry never overtakes another; latency input fire to out_valid is one cycle when empty.
REQ-022 SKID=0: in_ready = ~out_valid | out_ready (combinational); skid register absent; occupancy never exceeds 1.
REQ-023 out_ctrl SHALL be all-zero whenever out_valid=0, so an empty slot is a bubble that never writes back or accesses memory.
REQ-024 flush=1: next edge clears main and skid valid and control bits; data/dest fields keep old values; any input presented that cycle is dropped; flush overrides every simultaneous fire.
REQ-025 Output fire during flush cycle is honoured downstream (current entry was visible) but nothing replaces it.
REQ-026 occupancy = main_valid + skid_valid, registered.

Reset
REQ-027 rst low asynchronously clears main_valid, skid_valid, all control bits, data and dest fields to 0; out_valid=0, occupancy=0.
REQ-028 After reset release in_ready=1 in the first cycle; reset mid-transfer discards all held entries.

Structure
REQ-029 Control-bit positions (WB_en, MEM_R_EN, MEM_W_EN indices) and CTRL_W default belong in the shared pipeline package.
REQ-030 One entry-slot sub-module, pipe_slot (valid + packed fields, load enable, clear), instantiated once for main and once for skid under generate on SKID.
REQ-031 Flops reuse the codebase's existing enable register for data fields; valid/ctrl use async-clear flops.

Verification
REQ-032 Reset then in_valid=1, in_data0=0x0000_00AA, in_ctrl=3'b001, out_ready=1 -> next cycle out_valid=1, out_data0=0xAA, out_ctrl=3'b001, occupancy=1.
REQ-033 SKID=1, out_ready=0, push A=0x11 then B=0x22 -> occupancy=2, in_ready=0 next cycle; C held off; raise out_ready -> outputs 0x11, 0x22, then C in order.
REQ-034 occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flushed input never appears.
REQ-035 Continuous in_valid=1, out_ready=1 for 16 cycles with incrementing data -> one output per cycle, no gaps, no duplicates, in_ready stays 1.
REQ-036 SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid -> same-cycle replace, occupancy stays 1.
REQ-037 rst asserted low mid-stream at occupancy=2 -> out_valid and occupancy 0 immediately, before next clock edge.
